// File: rtl/qam_mapper.sv
// Packed-word to BPSK/QPSK/16-QAM symbol serialiser with valid/ready on both sides.
// Optional per-symbol output attenuation is enabled by defining QAM_MAPPER_GAIN_EN.
module qam_mapper #(
    parameter int IN_W      = 8,
    parameter int OUT_W     = 12,
    parameter int AMP_BPSK  = 2047,
    parameter int AMP_QPSK  = 1447,
    parameter int AMP_QAM16 = 647
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [IN_W-1:0]         i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    input  logic [1:0]              i_mode,
`ifdef QAM_MAPPER_GAIN_EN
    input  logic [1:0]              i_gain_sh,
`endif
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic signed [OUT_W-1:0] o_I,
    output logic signed [OUT_W-1:0] o_Q
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        MODE_BPSK  = 2'd0,
        MODE_QPSK  = 2'd1,
        MODE_QAM16 = 2'd2
    } mode_t;

    localparam logic signed [OUT_W-1:0] LVL_B_P  = OUT_W'(AMP_BPSK);
    localparam logic signed [OUT_W-1:0] LVL_B_N  = OUT_W'(-AMP_BPSK);
    localparam logic signed [OUT_W-1:0] LVL_Q_P  = OUT_W'(AMP_QPSK);
    localparam logic signed [OUT_W-1:0] LVL_Q_N  = OUT_W'(-AMP_QPSK);
    localparam logic signed [OUT_W-1:0] LVL_1D_P = OUT_W'(AMP_QAM16);
    localparam logic signed [OUT_W-1:0] LVL_1D_N = OUT_W'(-AMP_QAM16);
    localparam logic signed [OUT_W-1:0] LVL_3D_P = OUT_W'(3 * AMP_QAM16);
    localparam logic signed [OUT_W-1:0] LVL_3D_N = OUT_W'(-3 * AMP_QAM16);

    // Gray-coded 16-QAM axis level: 00 -> +3d, 01 -> +d, 11 -> -d, 10 -> -3d
    function automatic logic signed [OUT_W-1:0] gray_level(input logic [1:0] bits);
        case (bits)
            2'b00:   gray_level = LVL_3D_P;
            2'b01:   gray_level = LVL_1D_P;
            2'b11:   gray_level = LVL_1D_N;
            2'b10:   gray_level = LVL_3D_N;
            default: gray_level = '0;
        endcase
    endfunction

    logic [IN_W-1:0]         sr_r;
    logic [CNT_W-1:0]        cnt_r;
    mode_t                   mode_r;
    logic                    advance_s;
    logic                    load_s;
    logic                    emit_s;
    logic [IN_W-1:0]         sr_shift_s;
    logic signed [OUT_W-1:0] sym_i_s;
    logic signed [OUT_W-1:0] sym_q_s;
    logic signed [OUT_W-1:0] out_i_s;
    logic signed [OUT_W-1:0] out_q_s;
    mode_t                   load_mode_s;
    logic [CNT_W-1:0]        load_cnt_s;

    assign advance_s = !o_valid || i_ready;
    assign emit_s    = advance_s && (cnt_r != '0);
    // A new word may be taken while the last symbol of the current one leaves, so words abut.
    assign o_ready   = rst_n && ((cnt_r == '0) || ((cnt_r == CNT_W'(1)) && advance_s));
    assign load_s    = i_valid && o_ready;

    // Map the leading bits of the shift register and compute the shifted remainder.
    always_comb begin
        sym_i_s    = '0;
        sym_q_s    = '0;
        sr_shift_s = sr_r;
        case (mode_r)
            MODE_BPSK: begin
                sym_i_s    = sr_r[IN_W-1] ? LVL_B_N : LVL_B_P;
                sr_shift_s = sr_r << 3'd1;
            end
            MODE_QAM16: begin
                sym_i_s    = gray_level(sr_r[IN_W-1:IN_W-2]);
                sym_q_s    = gray_level(sr_r[IN_W-3:IN_W-4]);
                sr_shift_s = sr_r << 3'd4;
            end
            default: begin
                sym_i_s    = sr_r[IN_W-1] ? LVL_Q_N : LVL_Q_P;
                sym_q_s    = sr_r[IN_W-2] ? LVL_Q_N : LVL_Q_P;
                sr_shift_s = sr_r << 3'd2;
            end
        endcase
    end

    // Optional attenuation; arithmetic shift keeps the sign and floors toward -inf.
    always_comb begin
`ifdef QAM_MAPPER_GAIN_EN
        out_i_s = sym_i_s >>> i_gain_sh;
        out_q_s = sym_q_s >>> i_gain_sh;
`else
        out_i_s = sym_i_s;
        out_q_s = sym_q_s;
`endif
    end

    // Decode the incoming mode; the reserved code behaves as QPSK.
    always_comb begin
        case (i_mode)
            2'd0: begin
                load_mode_s = MODE_BPSK;
                load_cnt_s  = CNT_W'(IN_W);
            end
            2'd2: begin
                load_mode_s = MODE_QAM16;
                load_cnt_s  = CNT_W'(IN_W / 4);
            end
            default: begin
                load_mode_s = MODE_QPSK;
                load_cnt_s  = CNT_W'(IN_W / 2);
            end
        endcase
    end

    // Shift register, symbol counter, latched mode and registered output symbol.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr_r    <= '0;
            cnt_r   <= '0;
            mode_r  <= MODE_QPSK;
            o_valid <= 1'b0;
            o_I     <= '0;
            o_Q     <= '0;
        end else begin
            if (emit_s) begin
                o_I     <= out_i_s;
                o_Q     <= out_q_s;
                o_valid <= 1'b1;
                sr_r    <= sr_shift_s;
                cnt_r   <= cnt_r - CNT_W'(1);
            end else if (advance_s) begin
                o_valid <= 1'b0;
            end else begin
                o_valid <= o_valid;
            end
            // Only reachable with at most one symbol left, so the override drops nothing.
            if (load_s) begin
                sr_r   <= i_data;
                mode_r <= load_mode_s;
                cnt_r  <= load_cnt_s;
            end
        end
    end

endmodule

// File: tb/tb_qam_mapper.sv
// Directed bench for qam_mapper: reset, each mode, backpressure, back-to-back words, reset mid-word.
module tb_qam_mapper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [7:0]        i_data;
    logic              i_valid;
    logic              o_ready;
    logic [1:0]        i_mode;
    logic              o_valid;
    logic              i_ready;
    logic signed [11:0] o_I;
    logic signed [11:0] o_Q;
`ifdef QAM_MAPPER_GAIN_EN
    logic [1:0]        i_gain_sh = 2'd0;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic signed [11:0] QP = 12'sd1447;
    localparam logic signed [11:0] QN = -12'sd1447;
    localparam logic signed [11:0] BP = 12'sd2047;
    localparam logic signed [11:0] BN = -12'sd2047;

    qam_mapper dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_data   (i_data),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_mode   (i_mode),
`ifdef QAM_MAPPER_GAIN_EN
        .i_gain_sh(i_gain_sh),
`endif
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_I      (o_I),
        .o_Q      (o_Q)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [7:0] d, input logic [1:0] m);
        i_data  = d;
        i_mode  = m;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_data = 8'h00; i_mode = 2'd1;
        tick(); tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++; if (o_I !== 12'sd0 || o_Q !== 12'sd0) begin errors++; $display("FAIL reset_iq: got %0d,%0d expected 0,0", o_I, o_Q); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", o_ready); end
        rst_n = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", o_ready); end
    endtask

    task automatic test_qpsk();
        logic signed [11:0] ei [4];
        logic signed [11:0] eq [4];
        ei = '{QP, QP, QN, QN};
        eq = '{QP, QN, QP, QN};
        i_ready = 1'b1;
        send_word(8'h1B, 2'd1);
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL qpsk_latency: got %b expected 0", o_valid); end
        for (int s = 0; s < 4; s++) begin
            if (s >= 2) begin
                checks++;
                if (o_ready !== (s == 3)) begin errors++; $display("FAIL qpsk_ready sym%0d: got %b expected %b", s, o_ready, (s == 3)); end
            end
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_I !== ei[s] || o_Q !== eq[s]) begin
                errors++; $display("FAIL qpsk_sym%0d: got v=%b %0d,%0d expected v=1 %0d,%0d", s, o_valid, o_I, o_Q, ei[s], eq[s]);
            end
        end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_I !== QN || o_Q !== QN) begin
            errors++; $display("FAIL qpsk_idle_hold: got v=%b %0d,%0d expected v=0 %0d,%0d", o_valid, o_I, o_Q, QN, QN);
        end
    endtask

    task automatic test_reserved_mode();
        send_word(8'h1B, 2'd3);
        tick();
        checks++; if (o_I !== QP || o_Q !== QP) begin errors++; $display("FAIL mode3_sym0: got %0d,%0d expected %0d,%0d", o_I, o_Q, QP, QP); end
        tick();
        checks++; if (o_I !== QP || o_Q !== QN) begin errors++; $display("FAIL mode3_sym1: got %0d,%0d expected %0d,%0d", o_I, o_Q, QP, QN); end
        tick(); tick(); tick();
    endtask

    task automatic test_qam16();
        send_word(8'h4E, 2'd2);
        tick();
        checks++; if (o_valid !== 1'b1 || o_I !== 12'sd647 || o_Q !== 12'sd1941) begin errors++; $display("FAIL qam16_sym0: got v=%b %0d,%0d expected v=1 647,1941", o_valid, o_I, o_Q); end
        tick();
        checks++; if (o_valid !== 1'b1 || o_I !== -12'sd647 || o_Q !== -12'sd1941) begin errors++; $display("FAIL qam16_sym1: got v=%b %0d,%0d expected v=1 -647,-1941", o_valid, o_I, o_Q); end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL qam16_end: got %b expected 0", o_valid); end
    endtask

    task automatic test_bpsk();
        logic [7:0] d;
        logic signed [11:0] e;
        d = 8'hA5;
        send_word(d, 2'd0);
        for (int s = 0; s < 8; s++) begin
            tick();
            e = d[7-s] ? BN : BP;
            checks++;
            if (o_valid !== 1'b1 || o_I !== e || o_Q !== 12'sd0) begin
                errors++; $display("FAIL bpsk_sym%0d: got v=%b %0d,%0d expected v=1 %0d,0", s, o_valid, o_I, o_Q, e);
            end
        end
        tick();
    endtask

    task automatic test_backpressure();
        logic signed [11:0] ei [3];
        logic signed [11:0] eq [3];
        ei = '{QP, QN, QN};
        eq = '{QN, QP, QN};
        i_ready = 1'b1;
        send_word(8'h1B, 2'd1);
        tick();
        i_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_I !== QP || o_Q !== QP || o_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b rdy=%b %0d,%0d expected v=1 rdy=0 %0d,%0d", c, o_valid, o_ready, o_I, o_Q, QP, QP);
            end
        end
        i_ready = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            checks++;
            if (o_valid !== 1'b1 || o_I !== ei[s] || o_Q !== eq[s]) begin
                errors++; $display("FAIL bp_sym%0d: got v=%b %0d,%0d expected v=1 %0d,%0d", s + 1, o_valid, o_I, o_Q, ei[s], eq[s]);
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic signed [11:0] e;
        i_ready = 1'b1;
        i_data  = 8'h00; i_mode = 2'd1; i_valid = 1'b1;
        tick();
        i_data = 8'hFF; i_mode = 2'd0;
        for (int s = 0; s < 8; s++) begin
            if (s == 3) begin
                i_mode = 2'd1;
                checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b expected 1", o_ready); end
            end
            tick();
            if (s == 3) i_valid = 1'b0;
            e = (s < 4) ? QP : QN;
            checks++;
            if (o_valid !== 1'b1 || o_I !== e || o_Q !== e) begin
                errors++; $display("FAIL b2b_sym%0d: got v=%b %0d,%0d expected v=1 %0d,%0d", s, o_valid, o_I, o_Q, e, e);
            end
        end
        tick();
        checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL b2b_end: got %b expected 0", o_valid); end
    endtask

    task automatic test_reset_mid_word();
        i_ready = 1'b1;
        send_word(8'h1B, 2'd1);
        tick(); tick();
        checks++; if (o_I !== QP || o_Q !== QN) begin errors++; $display("FAIL rst_mid_sym1: got %0d,%0d expected %0d,%0d", o_I, o_Q, QP, QN); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready_low: got %b expected 0", o_ready); end
        tick();
        checks++;
        if (o_valid !== 1'b0 || o_I !== 12'sd0 || o_Q !== 12'sd0) begin
            errors++; $display("FAIL rst_mid_clear: got v=%b %0d,%0d expected v=0 0,0", o_valid, o_I, o_Q);
        end
        rst_n = 1'b1;
        #1;
        checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready_high: got %b expected 1", o_ready); end
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_no_emit%0d: got %b expected 0", c, o_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_qpsk();
        test_reserved_mode();
        test_qam16();
        test_bpsk();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qam_mapper.md
Name: qam_mapper

Overview:
- Parametrised successor to the single-symbol QPSK modulator.
- Accepts packed input bit words over a valid/ready handshake and serialises them into BPSK, QPSK or 16-QAM constellation symbols.
- Symbol mode is selectable at run time; the output port honours downstream backpressure.
- Sits between the framing/bit source and the pulse-shaping filter in the TX chain.

Parameters:
- IN_W, 8: input word width in bits; must be a multiple of 4.
- OUT_W, 12: signed output sample width.
- AMP_BPSK, 2047: BPSK I-axis magnitude.
- AMP_QPSK, 1447: QPSK per-axis magnitude (12'h5A7).
- AMP_QAM16, 647: 16-QAM unit level d; levels are ±d and ±3d. 3*AMP_QAM16 must fit in OUT_W signed.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- i_data  in  IN_W  packed bits, consumed MSB first.
- i_valid  in  1  i_data valid.
- o_ready  out  1  word accepted when i_valid & o_ready.
- i_mode  in  2  0=BPSK, 1=QPSK, 2=16QAM, 3=reserved (treated as QPSK).
- o_valid  out  1  symbol valid.
- i_ready  in  1  downstream ready.
- o_I  out  OUT_W  signed in-phase sample.
- o_Q  out  OUT_W  signed quadrature sample.

Behaviour:
- Clocking and reset: single clock domain. Reset is synchronous, active-low, sampled on the rising edge of clk.
- Reset values: o_valid=0, o_I=0, o_Q=0, shift register=0, symbol count cnt=0, latched mode=QPSK. o_ready=0 while rst_n=0.
- Reset mid-operation: discards any partially emitted word and any held output symbol.
- State: shift register sr[IN_W-1:0], cnt (symbols left in sr), latched mode m.
  - EMPTY: cnt==0.
  - ACTIVE: cnt>0.
- advance = !o_valid | i_ready.
- o_ready = rst_n & ((cnt==0) | (cnt==1 & advance)). This is combinational; no bubble between words.
- Word load (i_valid & o_ready):
  - sr <= i_data; m <= i_mode.
  - cnt <= IN_W, IN_W/2 or IN_W/4 for BPSK, QPSK or 16QAM respectively.
- Emit (advance & cnt>0):
  - Map the top k bits of sr (k=1/2/4) to a symbol and register it into o_I/o_Q; o_valid<=1.
  - sr shifts left by k; cnt decrements.
  - A load in the same cycle overrides sr/cnt with the new word. It is only possible when cnt==1, so no bits are lost.
- No emit on advance (cnt==0 and advance): o_valid<=0; o_I/o_Q hold their last value.
- Output hold: when o_valid & !i_ready, o_I, o_Q and o_valid hold. cnt and sr are frozen.
- Mapping (bits taken MSB first from the symbol):
  - BPSK: b=0 -> I=+AMP_BPSK; b=1 -> I=-AMP_BPSK. Q=0.
  - QPSK: bits [bI bQ]; 0 -> +AMP_QPSK, 1 -> -AMP_QPSK per axis.
  - 16QAM: bits [i1 i0 q1 q0], Gray coded per axis: 00->+3d, 01->+d, 11->-d, 10->-3d.
- Latency: a word accepted at edge k produces its first symbol on the outputs after edge k+1. Throughput is then one symbol per cycle while i_ready=1.
- i_mode changes take effect only at the next word load. A mode change mid-word is ignored for the remaining symbols of that word.
- All mapping arithmetic is two's complement in OUT_W bits. Levels are computed at elaboration from the parameters; no runtime multiply.

Optional Feature:
- Macro QAM_MAPPER_GAIN_EN.
- Defined: adds input port i_gain_sh [1:0]. The mapped level is arithmetic-shifted right by i_gain_sh (sign preserved, truncation toward -inf) before registering. i_gain_sh is sampled at emit time, per symbol.
- Undefined: the port does not exist and levels are registered unscaled.

Test Plan:
- QPSK, i_data=8'h1B, i_ready=1 -> 4 symbols (I,Q): (+1447,+1447), (+1447,-1447), (-1447,+1447), (-1447,-1447). o_ready high again in the cycle the 4th symbol is emitted.
- 16QAM, i_data=8'h4E -> (+647,+1941) then (-647,-1941).
- BPSK, i_data=8'hA5 -> I = -2047, +2047, -2047, +2047, +2047, -2047, +2047, -2047; Q=0 throughout.
- Backpressure: QPSK 8'h1B with i_ready=0 for 3 cycles after the first symbol -> symbol (+1447,+1447) held stable with o_valid=1; o_ready=0; remaining symbols follow in order with none dropped.
- Back-to-back: QPSK words 8'h00 then 8'hFF with i_valid held -> 8 contiguous valid symbols, 4× (+1447,+1447) then 4× (-1447,-1447). i_mode switched to BPSK during the first word -> the second word is still QPSK.
- Reset mid-word: assert rst_n=0 for 1 cycle after the 2nd symbol of 8'h1B -> o_valid=0, o_I=o_Q=0 on the next edge. The remaining symbols are never emitted; o_ready=1 once rst_n=1.
